// File: rtl/if_prefetch_pkg.sv
// Counter type and helpers for the instruction prefetcher and its buffer.
package if_prefetch_pkg;
    // Wide enough for 0..16, the largest legal DEPTH / MAX_OUT.
    localparam int CNT_W = 5;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t sat_dec(cnt_t v, logic dec);
        return (dec && (v != '0)) ? v - cnt_t'(1) : v;
    endfunction
endpackage

// File: rtl/rv_pkg.sv
// Core-wide RISC-V constants shared by the front-end blocks.
package rv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0100;
    localparam int PC_INC = 4;
endpackage

// File: rtl/if_prefetch_if.sv
// Push/pop/flush bundle between the prefetch control and its instruction FIFO.
interface if_prefetch_if #(
    parameter int XLEN = 32
);
    import if_prefetch_pkg::*;

    logic            push;
    logic [XLEN-1:0] push_data;
    logic            pop;
    logic            flush;
    cnt_t            count;
    logic [XLEN-1:0] head_data;

    modport master (output push, push_data, pop, flush, input count, head_data);
    modport slave  (input push, push_data, pop, flush, output count, head_data);
endinterface

// File: rtl/if_buf.sv
// Synchronous DEPTH x XLEN FIFO with flush; head data is read combinationally.
module if_buf
    import if_prefetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    if_prefetch_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    cnt_t            count_q;

    // Push and pop may coincide when full: the head is read before the write lands.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (bus.push) begin
                mem_q[wr_ptr_q] <= bus.push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (bus.pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + cnt_t'(bus.push) - cnt_t'(bus.pop);
        end
    end

    assign bus.count     = count_q;
    assign bus.head_data = mem_q[rd_ptr_q];
endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetcher: credit-limited in-order fetch into a small buffer,
// with redirect that flushes the buffer and drops stale responses.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int XLEN    = rv_pkg::XLEN,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rst_addr,
    input  logic            brh,
    input  logic [XLEN-1:0] brh_addr,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] inst
);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(rv_pkg::PC_INC);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] head_pc_q, head_pc_d;
    cnt_t            inflight_q, inflight_d;
    cnt_t            drop_q, drop_d;
    cnt_t            buf_count;
    logic            req_fire, rsp_take, pop, push;

    if_prefetch_if #(.XLEN(XLEN)) buf_bus ();

    if_buf #(.XLEN(XLEN), .DEPTH(DEPTH)) u_buf (
        .clk (clk),
        .rst (rst),
        .bus (buf_bus.slave)
    );

    // Buffered plus in-flight words never exceed DEPTH, so every response has a slot.
    assign imem_req_valid = !rst && !brh
                          && ((6'(buf_count) + 6'(inflight_q)) < 6'(DEPTH))
                          && (inflight_q < cnt_t'(MAX_OUT));
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_take       = imem_rsp_valid && (inflight_q != '0);
    assign out_valid      = !rst && (buf_count != '0);
    assign pop            = out_valid && out_ready && !brh;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q + cnt_t'(req_fire) - cnt_t'(rsp_take);
        drop_d     = drop_q;
        push       = 1'b0;
        if (brh) begin
            fetch_pc_d = brh_addr;
            head_pc_d  = brh_addr;
            // Every request still outstanding is now stale; drop_q already counts a subset of them.
            drop_d     = sat_dec(inflight_q, imem_rsp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (pop) begin
                head_pc_d = head_pc_q + PC_STEP;
            end
            if (rsp_take) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - cnt_t'(1);
                end else begin
                    push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= rst_addr;
            head_pc_q  <= rst_addr;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    assign buf_bus.push      = push;
    assign buf_bus.push_data = imem_rsp_data;
    assign buf_bus.pop       = pop;
    assign buf_bus.flush     = brh;
    assign buf_count         = buf_bus.count;
    assign pc                = head_pc_q;
    assign inst              = buf_bus.head_data;
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: per-cycle vector table, directed corner sequences and
// a randomized run against a queue-based memory/stream reference model.
module tb_if_prefetch;
    localparam int XLEN    = 32;
    localparam int DEPTH   = 4;
    localparam int MAX_OUT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [XLEN-1:0] rst_addr;
    logic            brh;
    logic [XLEN-1:0] brh_addr;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;

    if_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .rst            (rst),
        .rst_addr       (rst_addr),
        .brh            (brh),
        .brh_addr       (brh_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .pc             (pc),
        .inst           (inst)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // memory model: in-order requests with per-request latency
    typedef struct {
        logic [XLEN-1:0] addr;
        int unsigned     epoch;
        int unsigned     due;
    } req_t;

    req_t            memq[$];
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] fetch_m;
    int unsigned     epoch;
    int unsigned     cyc;
    int unsigned     dly_min, dly_max;
    int              checks, errors;
    int              n_req;
    logic            last_pop_valid;
    logic [XLEN-1:0] last_pop_pc;
    logic            obs_rv, obs_ov;
    logic [XLEN-1:0] obs_addr, obs_pc, obs_inst;

    function automatic logic [XLEN-1:0] inst_of(logic [XLEN-1:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1 ^ (a << 3);
    endfunction

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard: checks the current cycle at negedge, then advances the model
    task automatic observe();
        logic            exp_rv, exp_ov, fire;
        logic [XLEN-1:0] p;
        req_t            e;
        exp_rv = !rst && !brh && ((exp_q.size() + memq.size()) < DEPTH) && (memq.size() < MAX_OUT);
        exp_ov = !rst && (exp_q.size() > 0);
        obs_rv = imem_req_valid; obs_addr = imem_req_addr;
        obs_ov = out_valid; obs_pc = pc; obs_inst = inst;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) chk("req_addr", imem_req_addr, fetch_m);
        chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
        if (exp_ov) begin
            chk("out_pc", pc, exp_q[0]);
            chk("out_inst", inst, inst_of(exp_q[0]));
        end
        fire = exp_rv && imem_req_ready;
        if (rst) begin
            exp_q.delete();
            memq.delete();
            fetch_m = rst_addr;
            epoch++;
            last_pop_valid = 1'b0;
        end else begin
            if (imem_rsp_valid) begin
                e = memq.pop_front();
                if (!brh && e.epoch == epoch) exp_q.push_back(e.addr);
            end
            if (brh) begin
                exp_q.delete();
                epoch++;
                fetch_m = brh_addr;
                last_pop_valid = 1'b0;
            end else begin
                if (exp_ov && out_ready) begin
                    p = exp_q.pop_front();
                    if (last_pop_valid) chk("pc_step", pc, last_pop_pc + 32'd4);
                    last_pop_valid = 1'b1;
                    last_pop_pc = p;
                end
                if (fire) begin
                    memq.push_back('{addr: fetch_m, epoch: epoch,
                                     due: cyc + $urandom_range(dly_max, dly_min)});
                    fetch_m = fetch_m + 32'd4;
                    n_req++;
                end
            end
        end
    endtask

    // driver: one full clock cycle, entered and left at posedge + 1
    task automatic cycle(input logic r, input logic b, input logic [XLEN-1:0] ba,
                         input logic ordy, input logic qrdy);
        rst = r; brh = b; brh_addr = ba; out_ready = ordy; imem_req_ready = qrdy;
        if (!r && memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(memq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    typedef struct {
        logic            r;
        logic            b;
        logic [XLEN-1:0] ba;
        logic            ordy;
        logic            exp_rv;
        logic [XLEN-1:0] exp_addr;
        logic            exp_ov;
        logic [XLEN-1:0] exp_pc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int start, found;
        logic [XLEN-1:0] wrap_exp[3];
        checks = 0; errors = 0; n_req = 0; cyc = 0; epoch = 0;
        dly_min = 1; dly_max = 1;
        last_pop_valid = 1'b0;
        rst_addr = 32'h100; fetch_m = 32'h100;
        rst = 1'b1; brh = 1'b0; brh_addr = '0; out_ready = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        repeat (2) @(posedge clk);
        #1;

        // one-cycle memory, always ready: streaming start-up, then rst+brh together
        vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1, 32'h104};
        vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h110, 1'b1, 32'h108};
        vecs[6] = '{1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
        vecs[9] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].r, vecs[i].b, vecs[i].ba, vecs[i].ordy, 1'b1);
            chk("vec_req_valid", {31'b0, obs_rv}, {31'b0, vecs[i].exp_rv});
            if (vecs[i].exp_rv) chk("vec_req_addr", obs_addr, vecs[i].exp_addr);
            chk("vec_out_valid", {31'b0, obs_ov}, {31'b0, vecs[i].exp_ov});
            if (vecs[i].exp_ov) chk("vec_out_pc", obs_pc, vecs[i].exp_pc);
        end

        // buffer full with decode stalled: exactly DEPTH requests, refill after one pop
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        start = n_req;
        repeat (12) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("full_req_count", 32'(n_req - start), 32'd4);
        chk("full_req_valid", {31'b0, obs_rv}, 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        repeat (5) cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("refill_req_count", 32'(n_req - start), 32'd5);

        // redirect with two requests in flight: both responses dropped
        dly_min = 4; dly_max = 4;
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("two_in_flight", 32'(memq.size()), 32'd2);
        cycle(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
        dly_min = 1; dly_max = 1;
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (obs_ov) found = 1;
        end
        chk("redirect_out_seen", 32'(found), 32'd1);
        chk("redirect_first_pc", obs_pc, 32'h200);
        chk("redirect_first_inst", obs_inst, inst_of(32'h200));

        // fetch address wraps at the top of the address space
        wrap_exp[0] = 32'hFFFF_FFF8; wrap_exp[1] = 32'hFFFF_FFFC; wrap_exp[2] = 32'h0000_0000;
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
        found = 0;
        for (int i = 0; i < 12 && found < 3; i++) begin
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
            if (obs_rv) begin
                chk("wrap_req_addr", obs_addr, wrap_exp[found]);
                found++;
            end
        end
        chk("wrap_req_seen", 32'(found), 32'd3);

        // randomized ready, latency, redirects and resets
        dly_min = 1; dly_max = 4;
        for (int i = 0; i < 1000; i++) begin
            logic            r, b;
            logic [XLEN-1:0] ba;
            r  = ($urandom_range(299, 0) == 0);
            b  = !r && ($urandom_range(39, 0) == 0);
            ba = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            if (r) rst_addr = $urandom & 32'hFFFF_FFFC;
            cycle(r, b, ba, ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
